fpu_add_sequencer: RTL and testbench
====================================

Name: fpu_add_sequencer

Overview:
- Sequences one single-precision add at a time through the multi-cycle adder core.
- Screens operands on entry. Special cases (NaN, infinity, zero) are answered directly without using the adder.
- Normal operands start the adder, wait for its done strobe under a timeout watchdog, then hold the result until the consumer accepts it.
- Sits between the FPU top-level request interface and the adder datapath. It replaces the purely combinational exception-select path.

Parameters:
- DATA_WIDTH, 32, operand/result width (IEEE-754 single; only 32 supported).
- TIMEOUT, 16, maximum WAIT cycles allowed for add_done before aborting (must be >= 2).
- CNT_W, $clog2(TIMEOUT)+1, width of the watchdog counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  high only in IDLE.
- float_num1  in  32  operand A.
- float_num2  in  32  operand B.
- add_start  out  1  one-cycle start pulse to adder.
- add_a  out  32  operand A to adder; held stable from START through WAIT.
- add_b  out  32  operand B to adder; same hold rule as add_a.
- add_done  in  1  adder result-valid strobe.
- add_result  in  32  adder sum; sampled when add_done is high.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out  out  32  result word.
- exc_code  out  2  result classification: 00 adder, 01 zero bypass, 10 infinity, 11 invalid/NaN.
- timeout_err  out  1  result was produced by a watchdog abort.

Behaviour:
- Reset: state=IDLE; counter=0. Output values: in_ready=1 (combinational from IDLE); add_start=0, add_a=add_b=0, out_valid=0, out=0, exc_code=00, timeout_err=0.
- States: IDLE, START, WAIT, DONE.
- IDLE, in_valid=1: operands are latched and classified in the same cycle.
- Classification, in priority order:
  - (1) Either operand NaN (exp=FF, mant!=0) -> out=7FC00000, code 11.
  - (2) Both operands infinite with opposite signs -> out=7FC00000, code 11.
  - (3) Either operand infinite -> out=that infinity, code 10.
  - (4) float_num1 is ±0 (bits[30:0]=0) -> out=float_num2, code 01. Otherwise, if float_num2 is ±0 -> out=float_num1, code 01.
  - (5) All other operands, including denormals -> go to START.
- Cases 1-4 go directly to DONE. out_valid rises the cycle after acceptance (latency 1). add_start is never asserted for these cases.
- START: add_start=1 for exactly one cycle; add_a/add_b driven from the latched operands; counter cleared. Next state is WAIT.
- WAIT: counter increments each cycle.
  - add_done=1 -> out=add_result, code 00, go to DONE.
  - Otherwise, when counter reaches TIMEOUT-1 -> out=7FC00000, code 11, timeout_err=1, go to DONE.
  - add_done in the same cycle as the timeout terminal count: done wins, timeout_err=0.
- Normal-path latency: accept in cycle T, add_start in T+1, WAIT from T+2. add_done seen in cycle T+k gives out_valid in T+k+1.
- DONE: out_valid=1. out, exc_code and timeout_err are held stable while out_ready=0.
  - out_ready=1 -> out_valid falls next cycle, state goes to IDLE.
  - No same-cycle re-accept: in_ready stays 0 until back in IDLE.
- add_done outside WAIT is ignored, with no state or output change.
- in_valid while not in IDLE is ignored; operands are not sampled.
- Reset mid-operation (any state): forced to IDLE with the reset values above next cycle. A late add_done arriving after reset is ignored.
- timeout_err and exc_code are cleared when the next request is accepted.

Test Plan:
- Normal add: 3F800000 + 40000000, adder model asserts add_done 3 cycles after add_start with 40400000 -> exactly one add_start pulse, add_a/add_b stable, out=40400000, exc_code=00, out_valid one cycle after done.
- Infinity/NaN: 7F800000 + 3F800000 -> out=7F800000, code 10, out_valid at T+1, no add_start. 7F800000 + FF800000 -> 7FC00000, code 11. 7FC00001 + 7F800000 -> 7FC00000, code 11.
- Zero bypass: 00000000 + 40490FDB -> out=40490FDB, code 01. 80000000 + C0000000 -> out=C0000000, code 01. Neither case asserts add_start.
- Timeout: adder never asserts done, TIMEOUT=16 -> out=7FC00000, code 11, timeout_err=1 after 16 WAIT cycles. Separately, add_done on the terminal cycle -> adder result, timeout_err=0.
- Backpressure: out_ready held 0 for 5 cycles in DONE -> out and out_valid stable, in_ready=0, a new in_valid is ignored. out_ready=1 -> in_ready=1 in the following cycle.
- Reset in WAIT: assert rst for 1 cycle, then pulse add_done -> all outputs at reset values, out_valid stays 0. The next request (3F800000 + 3F800000 -> 40000000) completes normally.

Source files
------------

// File: rtl/fpu_add_sequencer_if.sv
// rtl/fpu_add_sequencer_if.sv - request, result and adder-core handshake bundle for fpu_add_sequencer
interface fpu_add_sequencer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] float_num1;
  logic [DATA_WIDTH-1:0] float_num2;
  logic                  add_start;
  logic [DATA_WIDTH-1:0] add_a;
  logic [DATA_WIDTH-1:0] add_b;
  logic                  add_done;
  logic [DATA_WIDTH-1:0] add_result;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out;
  logic [1:0]            exc_code;
  logic                  timeout_err;

  modport master (
    output in_valid, float_num1, float_num2, add_done, add_result, out_ready,
    input  in_ready, add_start, add_a, add_b, out_valid, out, exc_code, timeout_err
  );

  modport slave (
    input  in_valid, float_num1, float_num2, add_done, add_result, out_ready,
    output in_ready, add_start, add_a, add_b, out_valid, out, exc_code, timeout_err
  );
endinterface

// File: rtl/fpu_add_sequencer.sv
// rtl/fpu_add_sequencer.sv - one-at-a-time single-precision add sequencer with special-case bypass and watchdog
module fpu_add_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16,
  parameter int CNT_W      = $clog2(TIMEOUT) + 1
) (
  input logic                clk,
  input logic                rst,
  fpu_add_sequencer_if.slave io
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] EXC_ADD  = 2'b00;
  localparam logic [1:0] EXC_ZERO = 2'b01;
  localparam logic [1:0] EXC_INF  = 2'b10;
  localparam logic [1:0] EXC_NAN  = 2'b11;

  localparam logic [DATA_WIDTH-1:0] QNAN = DATA_WIDTH'(32'h7FC0_0000);
  localparam logic [CNT_W-1:0]      TERM = CNT_W'(TIMEOUT - 1);

  logic [1:0]            state;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [DATA_WIDTH-1:0] out_q;
  logic [1:0]            exc_q;
  logic                  terr_q;

  logic nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
  logic                  byp;
  logic [DATA_WIDTH-1:0] byp_out;
  logic [1:0]            byp_code;

  assign nan_a  = (&io.float_num1[30:23]) && (|io.float_num1[22:0]);
  assign nan_b  = (&io.float_num2[30:23]) && (|io.float_num2[22:0]);
  assign inf_a  = (&io.float_num1[30:23]) && ~(|io.float_num1[22:0]);
  assign inf_b  = (&io.float_num2[30:23]) && ~(|io.float_num2[22:0]);
  assign zero_a = ~(|io.float_num1[30:0]);
  assign zero_b = ~(|io.float_num2[30:0]);

  // Priority order matters: NaN beats inf-inf beats single inf beats zero.
  always_comb begin
    byp      = 1'b1;
    byp_out  = QNAN;
    byp_code = EXC_NAN;
    if (nan_a || nan_b) begin
      byp_out  = QNAN;
      byp_code = EXC_NAN;
    end else if (inf_a && inf_b && (io.float_num1[31] != io.float_num2[31])) begin
      byp_out  = QNAN;
      byp_code = EXC_NAN;
    end else if (inf_a) begin
      byp_out  = io.float_num1;
      byp_code = EXC_INF;
    end else if (inf_b) begin
      byp_out  = io.float_num2;
      byp_code = EXC_INF;
    end else if (zero_a) begin
      byp_out  = io.float_num2;
      byp_code = EXC_ZERO;
    end else if (zero_b) begin
      byp_out  = io.float_num1;
      byp_code = EXC_ZERO;
    end else begin
      byp      = 1'b0;
      byp_out  = '0;
      byp_code = EXC_ADD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      out_q  <= '0;
      exc_q  <= EXC_ADD;
      terr_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (io.in_valid) begin
            a_q    <= io.float_num1;
            b_q    <= io.float_num2;
            out_q  <= byp_out;
            exc_q  <= byp_code;
            terr_q <= 1'b0;
            state  <= byp ? S_DONE : S_START;
          end
        end
        S_START: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // A done strobe on the terminal count still wins over the abort.
          if (io.add_done) begin
            out_q  <= io.add_result;
            exc_q  <= EXC_ADD;
            terr_q <= 1'b0;
            state  <= S_DONE;
          end else if (cnt == TERM) begin
            out_q  <= QNAN;
            exc_q  <= EXC_NAN;
            terr_q <= 1'b1;
            state  <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (io.out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign io.in_ready    = (state == S_IDLE);
  assign io.add_start   = (state == S_START);
  assign io.add_a       = a_q;
  assign io.add_b       = b_q;
  assign io.out_valid   = (state == S_DONE);
  assign io.out         = out_q;
  assign io.exc_code    = exc_q;
  assign io.timeout_err = terr_q;
endmodule

// File: tb/tb_fpu_add_sequencer.sv
// tb/tb_fpu_add_sequencer.sv - directed self-checking bench for fpu_add_sequencer
module tb_fpu_add_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   start_cnt = 0;

  fpu_add_sequencer_if #(.DATA_WIDTH(32)) bus ();

  fpu_add_sequencer #(.DATA_WIDTH(32), .TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.add_start === 1'b1) start_cnt <= start_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, got running, expected finished");
    $fatal(1, "global timeout");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic [31:0] a, input logic [31:0] b);
    bus.in_valid   = 1'b1;
    bus.float_num1 = a;
    bus.float_num2 = b;
    cyc();
    bus.in_valid   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    n_checks++; if (bus.add_start !== 1'b0) begin n_fail++; $display("FAIL reset_add_start: got %b expected 0", bus.add_start); end
    n_checks++; if (bus.add_a !== 32'h0 || bus.add_b !== 32'h0) begin n_fail++; $display("FAIL reset_add_ab: got %h %h expected 0 0", bus.add_a, bus.add_b); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    n_checks++; if (bus.out !== 32'h0 || bus.exc_code !== 2'b00 || bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_out: got out=%h exc=%b terr=%b expected 0 00 0", bus.out, bus.exc_code, bus.timeout_err); end
  endtask

  task automatic test_normal_add();
    int s0;
    s0 = start_cnt;
    do_req(32'h3F80_0000, 32'h4000_0000);
    n_checks++; if (bus.add_start !== 1'b1) begin n_fail++; $display("FAIL normal_start_pulse: got %b expected 1", bus.add_start); end
    n_checks++; if (bus.add_a !== 32'h3F80_0000 || bus.add_b !== 32'h4000_0000) begin n_fail++; $display("FAIL normal_add_ab_start: got %h %h expected 3f800000 40000000", bus.add_a, bus.add_b); end
    cyc();
    n_checks++; if (bus.add_start !== 1'b0) begin n_fail++; $display("FAIL normal_start_single: got %b expected 0", bus.add_start); end
    cyc();
    cyc();
    n_checks++; if (bus.add_a !== 32'h3F80_0000 || bus.add_b !== 32'h4000_0000) begin n_fail++; $display("FAIL normal_add_ab_wait: got %h %h expected 3f800000 40000000", bus.add_a, bus.add_b); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL normal_early_valid: got %b expected 0", bus.out_valid); end
    bus.add_done   = 1'b1;
    bus.add_result = 32'h4040_0000;
    cyc();
    bus.add_done   = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL normal_valid_latency: got %b expected 1", bus.out_valid); end
    n_checks++; if (bus.out !== 32'h4040_0000 || bus.exc_code !== 2'b00 || bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL normal_result: got out=%h exc=%b terr=%b expected 40400000 00 0", bus.out, bus.exc_code, bus.timeout_err); end
    n_checks++; if (start_cnt - s0 !== 1) begin n_fail++; $display("FAIL normal_start_count: got %0d expected 1", start_cnt - s0); end
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;
    n_checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL normal_release: got in_ready=%b out_valid=%b expected 1 0", bus.in_ready, bus.out_valid); end
  endtask

  task automatic run_bypass(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_out, input logic [1:0] exp_code);
    int s0;
    s0 = start_cnt;
    do_req(a, b);
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bypass_valid %h+%h: got %b expected 1", a, b, bus.out_valid); end
    n_checks++; if (bus.out !== exp_out || bus.exc_code !== exp_code) begin n_fail++; $display("FAIL bypass_result %h+%h: got %h/%b expected %h/%b", a, b, bus.out, bus.exc_code, exp_out, exp_code); end
    n_checks++; if (bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL bypass_terr %h+%h: got %b expected 0", a, b, bus.timeout_err); end
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;
    n_checks++; if (start_cnt != s0) begin n_fail++; $display("FAIL bypass_no_start %h+%h: got %0d pulses expected 0", a, b, start_cnt - s0); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bypass_release %h+%h: got %b expected 1", a, b, bus.in_ready); end
  endtask

  task automatic test_infinity_nan();
    run_bypass(32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000, 2'b10);
    run_bypass(32'h3F80_0000, 32'hFF80_0000, 32'hFF80_0000, 2'b10);
    run_bypass(32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 2'b11);
    run_bypass(32'h7FC0_0001, 32'h7F80_0000, 32'h7FC0_0000, 2'b11);
    run_bypass(32'h0000_0000, 32'hFFC0_0000, 32'h7FC0_0000, 2'b11);
  endtask

  task automatic test_zero_bypass();
    run_bypass(32'h0000_0000, 32'h4049_0FDB, 32'h4049_0FDB, 2'b01);
    run_bypass(32'h8000_0000, 32'hC000_0000, 32'hC000_0000, 2'b01);
    run_bypass(32'h4049_0FDB, 32'h8000_0000, 32'h4049_0FDB, 2'b01);
  endtask

  task automatic test_timeout();
    int n;
    do_req(32'h3F80_0000, 32'h3F80_0000);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 40) begin
      cyc();
      n++;
    end
    n_checks++; if (n != 17) begin n_fail++; $display("FAIL timeout_latency: got %0d cycles after start expected 17", n); end
    n_checks++; if (bus.out !== 32'h7FC0_0000 || bus.exc_code !== 2'b11 || bus.timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_result: got %h/%b/%b expected 7fc00000/11/1", bus.out, bus.exc_code, bus.timeout_err); end
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_done_on_terminal();
    do_req(32'h3F80_0000, 32'h3F80_0000);
    repeat (16) cyc();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL terminal_early_abort: got %b expected 0", bus.out_valid); end
    bus.add_done   = 1'b1;
    bus.add_result = 32'h1234_5678;
    cyc();
    bus.add_done   = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out !== 32'h1234_5678 || bus.exc_code !== 2'b00 || bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL terminal_done_wins: got v=%b %h/%b/%b expected 1 12345678/00/0", bus.out_valid, bus.out, bus.exc_code, bus.timeout_err); end
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_back_pressure();
    int s0;
    do_req(32'h4000_0000, 32'h4000_0000);
    cyc();
    bus.add_done   = 1'b1;
    bus.add_result = 32'h4080_0000;
    cyc();
    bus.add_done   = 1'b0;
    s0 = start_cnt;
    bus.in_valid   = 1'b1;
    bus.float_num1 = 32'h7F80_0000;
    bus.float_num2 = 32'h3F80_0000;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out !== 32'h4080_0000 || bus.exc_code !== 2'b00 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL backpressure_hold[%0d]: got v=%b out=%h exc=%b in_ready=%b expected 1 40800000 00 0", i, bus.out_valid, bus.out, bus.exc_code, bus.in_ready); end
      cyc();
    end
    bus.in_valid  = 1'b0;
    n_checks++; if (bus.out !== 32'h4080_0000 || start_cnt != s0) begin n_fail++; $display("FAIL backpressure_ignored_req: got out=%h pulses=%0d expected 40800000 0", bus.out, start_cnt - s0); end
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;
    n_checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL backpressure_release: got in_ready=%b out_valid=%b expected 1 0", bus.in_ready, bus.out_valid); end
  endtask

  task automatic test_reset_in_wait();
    do_req(32'h3F80_0000, 32'h4000_0000);
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n_checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.add_a !== 32'h0 || bus.add_b !== 32'h0) begin n_fail++; $display("FAIL midreset_state: got in_ready=%b v=%b a=%h b=%h expected 1 0 0 0", bus.in_ready, bus.out_valid, bus.add_a, bus.add_b); end
    bus.add_done   = 1'b1;
    bus.add_result = 32'hDEAD_BEEF;
    cyc();
    bus.add_done   = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b0 || bus.out !== 32'h0 || bus.exc_code !== 2'b00 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_late_done: got v=%b out=%h exc=%b in_ready=%b expected 0 0 00 1", bus.out_valid, bus.out, bus.exc_code, bus.in_ready); end
    do_req(32'h3F80_0000, 32'h3F80_0000);
    cyc();
    bus.add_done   = 1'b1;
    bus.add_result = 32'h4000_0000;
    cyc();
    bus.add_done   = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out !== 32'h4000_0000 || bus.exc_code !== 2'b00) begin n_fail++; $display("FAIL midreset_next_req: got v=%b out=%h exc=%b expected 1 40000000 00", bus.out_valid, bus.out, bus.exc_code); end
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.float_num1 = 32'h0;
    bus.float_num2 = 32'h0;
    bus.add_done   = 1'b0;
    bus.add_result = 32'h0;
    bus.out_ready  = 1'b0;
    test_reset();
    test_normal_add();
    test_timeout();
    test_infinity_nan();
    test_zero_bypass();
    test_done_on_terminal();
    test_back_pressure();
    test_reset_in_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
